// File: rtl/imem_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_pkg
// Description : Shared CPU package for the instruction-memory fetch unit.
//               Holds the NOP instruction constant, the fetch-unit state
//               encoding and a byte-address to word-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_fetch_pkg;

    // Instruction returned for faulting fetches and written by the clear pass.
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Byte address to word index; callers keep the low log2(DEPTH) bits.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_if
// Description : Load/fetch bus between the CPU (and loader) and the
//               instruction memory.
//   master : drives ld_we/ld_addr/ld_data and fetch_req/fetch_addr,
//            receives ready/fetch_valid/fetch_inst/fetch_fault.
//   slave  : the instruction memory, opposite directions.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_if;

    logic        ready;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        fetch_fault;

    modport master (
        input  ready,
        input  fetch_valid,
        input  fetch_inst,
        input  fetch_fault,
        output ld_we,
        output ld_addr,
        output ld_data,
        output fetch_req,
        output fetch_addr
    );

    modport slave (
        output ready,
        output fetch_valid,
        output fetch_inst,
        output fetch_fault,
        input  ld_we,
        input  ld_addr,
        input  ld_data,
        input  fetch_req,
        input  fetch_addr
    );

endinterface
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : DEPTH x 32 single-clock RAM, one synchronous write port and
//               one synchronous read-first read port. No reset on the array
//               or on the read register.
// Ports       : clk      - clock
//               we_i     - write enable
//               waddr_i  - write word index
//               wdata_i  - write data
//               re_i     - read enable (read register holds when low)
//               raddr_i  - read word index
//               rdata_o  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          we_i,
    input  wire logic [AW-1:0] waddr_i,
    input  wire logic [31:0]   wdata_i,
    input  wire logic          re_i,
    input  wire logic [AW-1:0] raddr_i,
    output logic [31:0]        rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Both updates are non-blocking, so a same-cycle read of the written
    // word returns the old contents (read-first).
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch
// Description : Clocked instruction memory with registered fetch port,
//               program-load port, post-reset hardware clear and fetch
//               fault reporting (misaligned / out of range).
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - imem_fetch_if.slave:
//                      ready, ld_we/ld_addr/ld_data,
//                      fetch_req/fetch_addr,
//                      fetch_valid/fetch_inst/fetch_fault
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter int          DEPTH    = 64,
    parameter logic [31:0] NOP_WORD = NOP
) (
    input  wire logic   clk,
    input  wire logic   rst,
    imem_fetch_if.slave bus
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          ready_q;
    logic          valid_q;
    logic          fault_q;
    logic          nop_sel_q;   // fetch_inst shows NOP_WORD instead of RAM data

    logic          w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    logic [31:0]   w_ram_wdata;
    logic          w_ram_re;
    logic [31:0]   w_ram_rdata;

    logic [AW-1:0] w_ld_idx;
    logic [AW-1:0] w_fetch_idx;
    logic          w_ld_in_range;
    logic          w_fetch_fault;
    logic          w_fetch_accept;

    assign w_ld_idx    = AW'(word_index(bus.ld_addr));
    assign w_fetch_idx = AW'(word_index(bus.fetch_addr));

    // Range checks use every upper address bit so large addresses never
    // alias onto a low word.
    assign w_ld_in_range  = (bus.ld_addr[31:AW+2] == '0);
    assign w_fetch_fault  = (bus.fetch_addr[1:0] != 2'b00) ||
                            (bus.fetch_addr[31:AW+2] != '0);
    assign w_fetch_accept = bus.fetch_req && ready_q;

    // Write-port mux: the clear pass owns the port until ready.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = cnt_q;
        w_ram_wdata = NOP_WORD;
        if (state_q == ST_CLEAR) begin
            w_ram_we = 1'b1;
        end else if (bus.ld_we && w_ld_in_range) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = w_ld_idx;
            w_ram_wdata = bus.ld_data;
        end
    end

    // Only good fetches update the read register; otherwise it holds,
    // which keeps fetch_inst stable on idle cycles.
    assign w_ram_re = w_fetch_accept && !w_fetch_fault;

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .waddr_i (w_ram_waddr),
        .wdata_i (w_ram_wdata),
        .re_i    (w_ram_re),
        .raddr_i (w_fetch_idx),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            nop_sel_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == c_last_idx) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_fetch_accept) begin
                        valid_q   <= 1'b1;
                        fault_q   <= w_fetch_fault;
                        nop_sel_q <= w_fetch_fault;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Selects between two registered sources; no input reaches the outputs.
    assign bus.ready       = ready_q;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_inst  = nop_sel_q ? NOP_WORD : w_ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch
// Description : Self-checking bench for imem_fetch: directed scenarios plus
//               randomized load/fetch traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOPW  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_fetch_if bus ();

    imem_fetch #(
        .DEPTH    (DEPTH),
        .NOP_WORD (NOPW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    int          m_edges;       // rising edges since reset release
    logic        e_ready;
    logic        e_valid;
    logic        e_fault;
    logic [31:0] e_inst;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = NOPW;
        m_edges = 0;
        e_ready = 1'b0;
        e_valid = 1'b0;
        e_fault = 1'b0;
        e_inst  = NOPW;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ready"}, {31'd0, bus.ready},       {31'd0, e_ready});
        chk({tag, ".valid"}, {31'd0, bus.fetch_valid}, {31'd0, e_valid});
        chk({tag, ".fault"}, {31'd0, bus.fetch_fault}, {31'd0, e_fault});
        chk({tag, ".inst"},  bus.fetch_inst,           e_inst);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic cycle(input logic we, input logic [31:0] la, input logic [31:0] ldd,
                         input logic req, input logic [31:0] fa);
        bus.ld_we      = we;
        bus.ld_addr    = la;
        bus.ld_data    = ldd;
        bus.fetch_req  = req;
        bus.fetch_addr = fa;
        @(posedge clk);
        if (m_edges < DEPTH) begin
            // Clearing: inputs ignored, one word written per edge.
            m_mem[m_edges] = NOPW;
            m_edges++;
            e_valid = 1'b0;
            e_fault = 1'b0;
        end else begin
            if (req) begin
                e_valid = 1'b1;
                e_fault = (fa % 4 != 0) || (fa >= 4 * DEPTH);
                if (e_fault) e_inst = NOPW;
                else         e_inst = m_mem[fa / 4];
            end else begin
                e_valid = 1'b0;
                e_fault = 1'b0;
            end
            if (we && la < 4 * DEPTH) m_mem[la / 4] = ldd;
        end
        e_ready = (m_edges >= DEPTH);
        #1;
        check_outputs("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] fa);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, fa);
    endtask

    task automatic load(input logic [31:0] la, input logic [31:0] ldd);
        cycle(1'b1, la, ldd, 1'b0, 32'h0);
    endtask

    // Reset held for three cycles, released away from the clock edge.
    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("rst_async");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)       return {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
        else if (sel == 6) return {24'd0, 8'($urandom)};
        else if (sel == 7) return 32'h100 + {28'd0, 4'($urandom)};
        else if (sel == 8) return 32'($urandom);
        else               return 32'h0FC;
    endfunction

    initial begin
        bus.ld_we      = 1'b0;
        bus.ld_addr    = 32'h0;
        bus.ld_data    = 32'h0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 32'h0;

        apply_reset();

        // Clear phase: loads and fetches must be ignored.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0);
        chk("ready_after_clear", {31'd0, bus.ready}, 32'd1);

        fetch(32'h00);
        chk("clear_valid", {31'd0, bus.fetch_valid}, 32'd1);
        chk("clear_word0", bus.fetch_inst, NOPW);

        // Load and run
        load(32'h00, 32'h2001_0005);
        load(32'h04, 32'h2002_0006);
        load(32'h1C, 32'h0800_0000);
        fetch(32'h00);
        chk("run0", bus.fetch_inst, 32'h2001_0005);
        fetch(32'h04);
        chk("run1", bus.fetch_inst, 32'h2002_0006);
        fetch(32'h1C);
        chk("run7", bus.fetch_inst, 32'h0800_0000);
        chk("run7_fault", {31'd0, bus.fetch_fault}, 32'd0);

        // Faults
        fetch(32'h06);
        chk("mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
        chk("mis_inst", bus.fetch_inst, NOPW);
        fetch(32'h100);
        chk("oor_fault", {31'd0, bus.fetch_fault}, 32'd1);
        load(32'h100, 32'hDEAD_BEEF);
        fetch(32'h00);
        chk("no_alias", bus.fetch_inst, 32'h2001_0005);

        // Read-first collision
        load(32'h10, 32'h0C00_0007);
        cycle(1'b1, 32'h10, 32'h03E0_0008, 1'b1, 32'h10);
        chk("coll_old", bus.fetch_inst, 32'h0C00_0007);
        fetch(32'h10);
        chk("coll_new", bus.fetch_inst, 32'h03E0_0008);

        // Idle holds the last instruction
        idle(2);
        chk("hold_inst", bus.fetch_inst, 32'h03E0_0008);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 2) == 0), rand_addr(), 32'($urandom),
                  ($urandom_range(0, 3) != 0), rand_addr());
        end

        // Reset while fetch_valid is high
        load(32'h00, 32'h1234_5678);
        fetch(32'h00);
        chk("pre_rst_valid", {31'd0, bus.fetch_valid}, 32'd1);
        chk("pre_rst_inst", bus.fetch_inst, 32'h1234_5678);
        #1;
        apply_reset();
        chk("mid_rst_valid", {31'd0, bus.fetch_valid}, 32'd0);
        chk("mid_rst_inst", bus.fetch_inst, NOPW);
        idle(DEPTH);
        fetch(32'h00);
        chk("reclear_word0", bus.fetch_inst, NOPW);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_fetch.md
# imem_fetch

Parametrised, clocked instruction memory for the single-cycle/multi-cycle CPU datapath. It replaces the fixed 8-word combinational ROM with a DEPTH-word RAM that has:
- a registered fetch port with request/valid handshake;
- a program-load write port;
- a hardware clear sequence after reset;
- fault reporting for misaligned or out-of-range fetch addresses.

It sits between the PC register and the decode stage. The loader (testbench or boot logic) drives the load port.

## Interface
Parameters:
- DEPTH, default 64: number of 32-bit words. Power of two, minimum 8.
- NOP_WORD, default 32'h00000000: value written by the clear sequence and returned on a fault.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high once the clear sequence is complete; fetches and loads are accepted only while high.
- ld_we  in  1  load write enable.
- ld_addr  in  32  load byte address; bits [1:0] are ignored.
- ld_data  in  32  load write data.
- fetch_req  in  1  fetch request.
- fetch_addr  in  32  fetch byte address (the PC).
- fetch_valid  out  1  fetch result valid, one cycle after an accepted request.
- fetch_inst  out  32  fetched instruction.
- fetch_fault  out  1  the accepted request was misaligned or out of range.

## Operation
- State machine: CLEAR → READY.
- Reset (asynchronous):
  - state = CLEAR, clear counter = 0;
  - ready = 0, fetch_valid = 0, fetch_fault = 0, fetch_inst = NOP_WORD.
- CLEAR:
  - writes NOP_WORD to word[counter] each cycle, counter += 1;
  - after word DEPTH-1 is written, moves to READY;
  - ld_we and fetch_req are ignored; no fetch_valid is produced.
- READY:
  - ld_we = 1 writes ld_data to word[ld_addr[log2(DEPTH)+1:2]];
  - a load with ld_addr ≥ 4·DEPTH is dropped silently, with no side effect.
- Fetch, accepted when fetch_req = 1 and ready = 1:
  - fault = (fetch_addr[1:0] ≠ 0) or (fetch_addr ≥ 4·DEPTH);
  - next cycle: fetch_valid = 1, fetch_fault = fault;
  - fetch_inst = NOP_WORD if fault, else word[fetch_addr[log2(DEPTH)+1:2]].
- The fault check uses the full 32-bit address; there is no wrap-around aliasing.
- If fetch_req = 0 (or ready = 0), the next cycle has fetch_valid = 0 and fetch_fault = 0, and fetch_inst holds its last value.
- Load and fetch to the same word in the same cycle is read-first: the fetch returns the old contents, and the new data is visible from the next request onward.
- Reset asserted mid-operation: outputs return to their reset values immediately, the memory is fully re-cleared, and previously loaded program contents are lost.

## Timing
- Clear sequence: ready rises on the DEPTH-th rising edge after rst deasserts (64 cycles at the default).
- Fetch latency: 1 cycle, request to fetch_valid. Back-to-back requests are accepted every cycle, giving throughput of 1 per cycle.
- Load: takes effect at the clock edge; a fetch issued in the following cycle sees the new data.
- No combinational path from fetch_* or ld_* inputs to any output. All outputs are registered, apart from the async reset.

## Structure
- Shared CPU package holds:
  - NOP constant 32'h00000000;
  - state encoding CLEAR / READY (enum);
  - helper function for address-to-word-index.
- One sub-module, imem_ram: a DEPTH×32 RAM with one synchronous write port and one synchronous read-first read port, with no reset on the array.
- imem_fetch contains:
  - the FSM and clear counter;
  - the write-port mux (clear vs. load);
  - fault logic;
  - output registers.

## Test plan
- Clear: reset, hold rst for 3 cycles, then release.
  - ready = 0 for 64 cycles, then 1.
  - Fetch 0x00 → fetch_valid = 1, fetch_inst = 0x00000000, fetch_fault = 0.
- Load and run: load 0x20010005 @0x00, 0x20020006 @0x04, 0x08000000 @0x1C; then fetch 0x00, 0x04, 0x1C on consecutive cycles.
  - Three consecutive fetch_valid cycles returning exactly those words, with fetch_fault = 0.
- Faults:
  - fetch 0x06 → fetch_fault = 1, fetch_inst = 0x00000000;
  - fetch 0x100 with DEPTH = 64 → fetch_fault = 1;
  - load to 0x100 → memory unchanged, with no alias onto word 0.
- Collision: word 0x10 = 0x0c000007; in the same cycle load 0x03e00008 @0x10 and fetch 0x10.
  - This fetch returns 0x0c000007; the next fetch of 0x10 returns 0x03e00008.
- Not ready: fetch_req and ld_we asserted during CLEAR.
  - fetch_valid stays 0, and no load takes effect.
- Reset mid-run: assert rst while fetch_valid = 1.
  - Outputs go to reset values within the same cycle.
  - After re-clear, a fetch of the previously loaded 0x00 returns 0x00000000.
